// File: rtl/wishbone_march_master_pkg.sv
// Shared definitions for the Wishbone march tester: FSM encoding, pattern modes
// and the word-to-byte address helper.
package wishbone_march_master_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WR_REQ = 3'd1;
    localparam logic [2:0] ST_WR_GAP = 3'd2;
    localparam logic [2:0] ST_RD_REQ = 3'd3;
    localparam logic [2:0] ST_RD_GAP = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [1:0] {
        MODE_XOR   = 2'd0,
        MODE_SEED  = 2'd1,
        MODE_WALK1 = 2'd2,
        MODE_XNOR  = 2'd3
    } march_mode_e;

    // Base is stored word-aligned, so plain 32-bit addition gives the modulo-2^32 wrap.
    function automatic logic [31:0] word_adr(input logic [31:0] base, input logic [29:0] idx);
        return base + {idx, 2'b00};
    endfunction

endpackage

// File: rtl/wishbone_march_master_pattern.sv
// Pattern generator: pure function of (mode, seed, idx), shared by the write data
// path and the read-back compare so both always agree.
module wishbone_march_master_pattern
    import wishbone_march_master_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [31:0] seed,
    input  logic [31:0] idx,
    output logic [31:0] word
);

    always_comb begin
        word = idx ^ seed;
        case (march_mode_e'(mode))
            MODE_XOR:   word = idx ^ seed;
            MODE_SEED:  word = seed;
            MODE_WALK1: word = 32'd1 << idx[4:0];
            MODE_XNOR:  word = ~(idx ^ seed);
            default:    word = idx ^ seed;
        endcase
    end

endmodule

// File: rtl/wishbone_march_master.sv
// Wishbone march tester: writes a generated pattern over a word range, reads it back,
// and reports pass/fail, mismatch count and the first failing byte address.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for a start rising edge, status all clear
//   ST_WR_REQ  | write strobe held until ack or timeout
//   ST_WR_GAP  | one idle cycle so the bridge sees stb fall before next write
//   ST_RD_REQ  | read strobe held until ack or timeout; compare on ack
//   ST_RD_GAP  | one idle cycle before the next read
//   ST_DONE    | status valid and sticky until the next start rising edge
module wishbone_march_master
    import wishbone_march_master_pkg::*;
#(
    parameter int WORD_AW = 14,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [31:0]        seed_i,
    input  logic [31:0]        base_adr_i,
    input  logic [WORD_AW:0]   count_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic               timeout_o,
    output logic [15:0]        err_cnt_o,
    output logic [31:0]        fail_adr_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [3:0]         wbm_sel_o,
    output logic [31:0]        wbm_adr_o,
    output logic [31:0]        wbm_dat_o,
    input  logic               wbm_ack_i,
    input  logic [31:0]        wbm_dat_i
);

    // Down-counter loaded on each strobe entry; reaching zero without ack means
    // the strobe has been high for exactly TIMEOUT cycles.
    localparam logic [7:0]       TMR_LOAD = 8'(TIMEOUT - 1);
    localparam logic [WORD_AW:0] IDX_ONE  = (WORD_AW+1)'(1);

    logic [2:0]         state;
    logic               start_q;
    logic [1:0]         mode_r;
    logic [31:0]        seed_r;
    logic [31:0]        base_r;
    logic [WORD_AW:0]   count_r;
    logic [WORD_AW:0]   idx;
    logic [7:0]         timer;
    logic               done_r;
    logic               timeout_r;
    logic [15:0]        err_cnt;
    logic [31:0]        fail_adr;

    logic               start_rise;
    logic               stb;
    logic               last_idx;
    logic               tmr_expired;
    logic               mismatch;
    logic [31:0]        pattern;
    logic [31:0]        cur_adr;

    wishbone_march_master_pattern u_pattern (
        .mode (mode_r),
        .seed (seed_r),
        .idx  (32'(idx)),
        .word (pattern)
    );

    assign start_rise  = start_i & ~start_q;
    assign stb         = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    assign last_idx    = (idx == count_r - IDX_ONE);
    assign tmr_expired = (timer == 8'd0);
    assign mismatch    = (wbm_dat_i != pattern);
    assign cur_adr     = word_adr(base_r, 30'(idx));

    assign busy_o     = stb || (state == ST_WR_GAP) || (state == ST_RD_GAP);
    assign done_o     = done_r;
    assign timeout_o  = timeout_r;
    assign pass_o     = done_r & ~timeout_r & (err_cnt == 16'd0);
    assign err_cnt_o  = err_cnt;
    assign fail_adr_o = fail_adr;
    assign wbm_cyc_o  = stb;
    assign wbm_stb_o  = stb;
    assign wbm_we_o   = (state == ST_WR_REQ);
    assign wbm_sel_o  = stb ? 4'hF : 4'h0;
    assign wbm_adr_o  = stb ? cur_adr : 32'd0;
    assign wbm_dat_o  = (state == ST_WR_REQ) ? pattern : 32'd0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= ST_IDLE;
            start_q   <= 1'b0;
            mode_r    <= 2'd0;
            seed_r    <= 32'd0;
            base_r    <= 32'd0;
            count_r   <= '0;
            idx       <= '0;
            timer     <= 8'd0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            err_cnt   <= 16'd0;
            fail_adr  <= 32'd0;
        end else begin
            start_q <= start_i;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_rise) begin
                        mode_r    <= mode_i;
                        seed_r    <= seed_i;
                        base_r    <= {base_adr_i[31:2], 2'b00};
                        count_r   <= count_i;
                        idx       <= '0;
                        timer     <= TMR_LOAD;
                        err_cnt   <= 16'd0;
                        fail_adr  <= 32'd0;
                        timeout_r <= 1'b0;
                        if (count_i == '0) begin
                            done_r <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            done_r <= 1'b0;
                            state  <= ST_WR_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (wbm_ack_i) begin
                        if (last_idx) begin
                            idx   <= '0;
                            state <= ST_RD_GAP;
                        end else begin
                            idx   <= idx + IDX_ONE;
                            state <= ST_WR_GAP;
                        end
                    end else if (tmr_expired) begin
                        timeout_r <= 1'b1;
                        done_r    <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                ST_WR_GAP: begin
                    timer <= TMR_LOAD;
                    state <= ST_WR_REQ;
                end
                ST_RD_GAP: begin
                    timer <= TMR_LOAD;
                    state <= ST_RD_REQ;
                end
                ST_RD_REQ: begin
                    if (wbm_ack_i) begin
                        if (mismatch) begin
                            if (err_cnt == 16'd0)
                                fail_adr <= cur_adr;
                            if (err_cnt != 16'hFFFF)
                                err_cnt <= err_cnt + 16'd1;
                        end
                        if (last_idx) begin
                            done_r <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            idx   <= idx + IDX_ONE;
                            state <= ST_RD_GAP;
                        end
                    end else if (tmr_expired) begin
                        timeout_r <= 1'b1;
                        done_r    <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
